// File: rtl/otter_mem_arbiter_if.sv
// Bus bundle for the OTTER memory arbiter: three requester ports plus the single memory port.
// The slave modport is the arbiter's view; the master modport is the requester/memory side.
interface otter_mem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic [2:0]              MA_REQ;
    logic [2:0]              MA_WE;
    logic [3*ADDR_W-1:0]     MA_ADDR;
    logic [3*DATA_W-1:0]     MA_WDATA;
    logic [3*(DATA_W/8)-1:0] MA_BE;
    logic                    MA_PROG_LOCK;
    logic [2:0]              MA_ACK;
    logic [DATA_W-1:0]       MA_RDATA;
    logic [1:0]              MA_GNT_ID;
    logic                    MA_BUSY;
    logic                    MA_ERR;
    logic                    MEM_REQ;
    logic                    MEM_WE;
    logic [ADDR_W-1:0]       MEM_ADDR;
    logic [DATA_W-1:0]       MEM_WDATA;
    logic [DATA_W/8-1:0]     MEM_BE;
    logic                    MEM_ACK;
    logic [DATA_W-1:0]       MEM_RDATA;

    modport slave (
        input  MA_REQ, MA_WE, MA_ADDR, MA_WDATA, MA_BE, MA_PROG_LOCK, MEM_ACK, MEM_RDATA,
        output MA_ACK, MA_RDATA, MA_GNT_ID, MA_BUSY, MA_ERR,
               MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
    );

    modport master (
        output MA_REQ, MA_WE, MA_ADDR, MA_WDATA, MA_BE, MA_PROG_LOCK, MEM_ACK, MEM_RDATA,
        input  MA_ACK, MA_RDATA, MA_GNT_ID, MA_BUSY, MA_ERR,
               MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, MEM_BE
    );
endinterface

// File: rtl/otter_mem_arbiter.sv
// Shares the OTTER memory port between fetch (0), load/store (1) and the UART programmer (2).
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise fixed priority 2 > 1 > 0.
module otter_mem_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 255
) (
    input logic                MA_CLK,
    input logic                MA_RESET,
    otter_mem_arbiter_if.slave bus
);
    localparam int BE_W  = DATA_W / 8;
    localparam int CNT_W = (TIMEOUT_CYC == 0) ? 1 : $clog2(TIMEOUT_CYC + 1);
    localparam logic [DATA_W-1:0] ERR_DATA = DATA_W'(32'hDEAD_BEEF);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t              state_q, state_d;
    logic [1:0]          owner_q, owner_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          eligible;
    logic [1:0]          winner;
`ifdef MEM_ARB_RR_EN
    logic [1:0]          ptr_q, ptr_d;
    logic                found;
`endif

    // Lock masks fetch and load/store; their requests simply stay pending until it drops.
    always_comb begin
        eligible = bus.MA_REQ & (bus.MA_PROG_LOCK ? 3'b100 : 3'b111);
        winner   = 2'd0;
`ifdef MEM_ARB_RR_EN
        found    = 1'b0;
        for (int k = 0; k < 3; k++) begin
            if (!found && eligible[(int'(ptr_q) + k) % 3]) begin
                winner = 2'((int'(ptr_q) + k) % 3);
                found  = 1'b1;
            end
        end
`else
        if (eligible[2]) begin
            winner = 2'd2;
        end else if (eligible[1]) begin
            winner = 2'd1;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        be_d    = be_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        cnt_d   = cnt_q;
`ifdef MEM_ARB_RR_EN
        ptr_d   = ptr_q;
`endif
        case (state_q)
            IDLE: begin
                if (|eligible) begin
                    state_d = BUSY;
                    owner_d = winner;
                    we_d    = bus.MA_WE[winner];
                    addr_d  = bus.MA_ADDR[int'(winner)*ADDR_W +: ADDR_W];
                    wdata_d = bus.MA_WDATA[int'(winner)*DATA_W +: DATA_W];
                    be_d    = bus.MA_BE[int'(winner)*BE_W +: BE_W];
                    cnt_d   = '0;
`ifdef MEM_ARB_RR_EN
                    ptr_d   = (winner == 2'd2) ? 2'd0 : winner + 2'd1;
`endif
                end
            end
            BUSY: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.MEM_ACK) begin
                    rdata_d = bus.MEM_RDATA;
                    state_d = DONE;
                end else if ((TIMEOUT_CYC != 0) &&
                             ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT_CYC))) begin
                    err_d   = 1'b1;
                    rdata_d = ERR_DATA;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge MA_CLK or posedge MA_RESET) begin
        if (MA_RESET) begin
            state_q <= IDLE;
            owner_q <= 2'd0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            be_q    <= be_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
`ifdef MEM_ARB_RR_EN
            ptr_q   <= ptr_d;
`endif
        end
    end

    // Handshake outputs decode straight from state so reset drops MEM_REQ without a clock.
    assign bus.MA_ACK    = (state_q == DONE) ? (3'b001 << owner_q) : 3'b000;
    assign bus.MA_RDATA  = rdata_q;
    assign bus.MA_GNT_ID = (state_q == IDLE) ? 2'b11 : owner_q;
    assign bus.MA_BUSY   = (state_q != IDLE);
    assign bus.MA_ERR    = err_q;
    assign bus.MEM_REQ   = (state_q == BUSY);
    assign bus.MEM_WE    = (state_q == BUSY) && we_q;
    assign bus.MEM_ADDR  = addr_q;
    assign bus.MEM_WDATA = wdata_q;
    assign bus.MEM_BE    = be_q;
endmodule

// File: tb/tb_otter_mem_arbiter.sv
// Scoreboard bench for otter_mem_arbiter: directed transactions push expected responses,
// a negedge monitor pops and compares them whenever an ACK pulse appears.
module tb_otter_mem_arbiter;
    localparam int MEM_DELAY = 1;

    typedef struct packed {
        logic [2:0]  ack;
        logic [1:0]  gnt;
        logic [31:0] rdata;
        logic        err;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic [7:0]  busyLen;
    } expect_t;

    logic        clk;
    logic        rst;
    logic        memEnable;
    expect_t     expQ[$];
    int          checks = 0;
    int          failures = 0;
    int          cycleCnt = 0;
    int          lastAckCycle = -1;
    int          waitCnt = 0;
    int          busyRun = 0;
    logic        capWe;
    logic [31:0] capAddr;
    logic [31:0] capWdata;
    logic [3:0]  capBe;

    otter_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    otter_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYC(4)) dut (
        .MA_CLK   (clk),
        .MA_RESET (rst),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cycleCnt <= cycleCnt + 1;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%08h required=0x%08h", name, actual, expected);
        end
    endtask

    function automatic logic [31:0] memData(input logic [31:0] addr);
        return (addr == 32'h100) ? 32'h0000_0013 : ~addr;
    endfunction

    task automatic pushExpect(input int port, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be,
                              input logic [31:0] rdata, input logic err, input int busyLen);
        expect_t e;
        e.ack     = 3'b001 << port;
        e.gnt     = 2'(port);
        e.rdata   = rdata;
        e.err     = err;
        e.we      = we;
        e.addr    = addr;
        e.wdata   = wdata;
        e.be      = be;
        e.busyLen = 8'(busyLen);
        expQ.push_back(e);
    endtask

    task automatic applyStimulus(input int port, input logic we, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [3:0] be);
        bus.MA_WE[port]             = we;
        bus.MA_ADDR[port*32 +: 32]  = addr;
        bus.MA_WDATA[port*32 +: 32] = wdata;
        bus.MA_BE[port*4 +: 4]      = be;
        bus.MA_REQ[port]            = 1'b1;
    endtask

    task automatic waitAcks(input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk);
            if (bus.MA_ACK != 3'b000) begin
                bus.MA_REQ = bus.MA_REQ & ~bus.MA_ACK;
                got++;
            end
        end
        if (got < n) checkOutput("ack_wait_expired", 32'(got), 32'(n));
    endtask

    // Memory model: acknowledges MEM_DELAY cycles into BUSY, returning memData(address).
    initial begin
        bus.MEM_ACK   = 1'b0;
        bus.MEM_RDATA = 32'h0;
        forever begin
            @(negedge clk);
            if (bus.MEM_REQ && memEnable) begin
                if (waitCnt >= MEM_DELAY) begin
                    bus.MEM_ACK   = 1'b1;
                    bus.MEM_RDATA = memData(bus.MEM_ADDR);
                    waitCnt       = 0;
                end else begin
                    bus.MEM_ACK = 1'b0;
                    waitCnt++;
                end
            end else begin
                bus.MEM_ACK = 1'b0;
                waitCnt     = 0;
            end
        end
    end

    initial begin
        expect_t e;
        forever begin
            @(negedge clk);
            if (bus.MEM_REQ) begin
                busyRun++;
                capWe    = bus.MEM_WE;
                capAddr  = bus.MEM_ADDR;
                capWdata = bus.MEM_WDATA;
                capBe    = bus.MEM_BE;
            end else begin
                if (bus.MA_ACK != 3'b000) begin
                    if (expQ.size() == 0) begin
                        checkOutput("unexpected_ack", 32'(bus.MA_ACK), 32'h0);
                    end else begin
                        e = expQ.pop_front();
                        checkOutput("ack_vec",   32'(bus.MA_ACK),    32'(e.ack));
                        checkOutput("gnt_id",    32'(bus.MA_GNT_ID), 32'(e.gnt));
                        checkOutput("rdata",     bus.MA_RDATA,       e.rdata);
                        checkOutput("err",       32'(bus.MA_ERR),    32'(e.err));
                        checkOutput("mem_we",    32'(capWe),         32'(e.we));
                        checkOutput("mem_addr",  capAddr,            e.addr);
                        checkOutput("mem_wdata", capWdata,           e.wdata);
                        checkOutput("mem_be",    32'(capBe),         32'(e.be));
                        checkOutput("busy_len",  32'(busyRun),       32'(e.busyLen));
                    end
                    if (lastAckCycle >= 0)
                        checkOutput("ack_spacing", 32'((cycleCnt - lastAckCycle) >= 3), 32'd1);
                    lastAckCycle = cycleCnt;
                end
                busyRun = 0;
            end
        end
    end

    initial begin
        rst              = 1'b1;
        memEnable        = 1'b1;
        bus.MA_REQ       = 3'b000;
        bus.MA_WE        = 3'b000;
        bus.MA_ADDR      = '0;
        bus.MA_WDATA     = '0;
        bus.MA_BE        = '0;
        bus.MA_PROG_LOCK = 1'b0;
        #12;
        checkOutput("rst_gnt",     32'(bus.MA_GNT_ID), 32'd3);
        checkOutput("rst_ack",     32'(bus.MA_ACK),    32'd0);
        checkOutput("rst_busy",    32'(bus.MA_BUSY),   32'd0);
        checkOutput("rst_err",     32'(bus.MA_ERR),    32'd0);
        checkOutput("rst_memreq",  32'(bus.MEM_REQ),   32'd0);
        checkOutput("rst_rdata",   bus.MA_RDATA,       32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Fetch read; the payload changes after the grant and must be ignored.
        @(negedge clk);
        pushExpect(0, 1'b0, 32'h100, 32'h0, 4'hF, 32'h0000_0013, 1'b0, 2);
        applyStimulus(0, 1'b0, 32'h100, 32'h0, 4'hF);
        @(negedge clk);
        checkOutput("t1_gnt_busy", 32'(bus.MA_GNT_ID), 32'd0);
        bus.MA_ADDR[31:0] = 32'h999;
        waitAcks(1, 20);
        @(negedge clk);
        checkOutput("t1_gnt_idle", 32'(bus.MA_GNT_ID), 32'd3);

        // All three ports request together; pointer is 1 after the fetch grant.
`ifdef MEM_ARB_RR_EN
        pushExpect(1, 1'b0, 32'h310, 32'h0, 4'hF, 32'hFFFF_FCEF, 1'b0, 2);
        pushExpect(2, 1'b0, 32'h320, 32'h0, 4'hF, 32'hFFFF_FCDF, 1'b0, 2);
        pushExpect(0, 1'b0, 32'h300, 32'h0, 4'hF, 32'hFFFF_FCFF, 1'b0, 2);
`else
        pushExpect(2, 1'b0, 32'h320, 32'h0, 4'hF, 32'hFFFF_FCDF, 1'b0, 2);
        pushExpect(1, 1'b0, 32'h310, 32'h0, 4'hF, 32'hFFFF_FCEF, 1'b0, 2);
        pushExpect(0, 1'b0, 32'h300, 32'h0, 4'hF, 32'hFFFF_FCFF, 1'b0, 2);
`endif
        applyStimulus(0, 1'b0, 32'h300, 32'h0, 4'hF);
        applyStimulus(1, 1'b0, 32'h310, 32'h0, 4'hF);
        applyStimulus(2, 1'b0, 32'h320, 32'h0, 4'hF);
        waitAcks(3, 40);

        // Programmer lock: port 2 is served, the CPU write waits until the lock drops.
        @(negedge clk);
        bus.MA_PROG_LOCK = 1'b1;
        pushExpect(2, 1'b0, 32'h40, 32'h0, 4'h3, 32'hFFFF_FFBF, 1'b0, 2);
        applyStimulus(1, 1'b1, 32'h2000, 32'hCAFE_F00D, 4'hF);
        applyStimulus(2, 1'b0, 32'h40, 32'h0, 4'h3);
        waitAcks(1, 20);
        repeat (5) @(negedge clk);
        checkOutput("lock_gnt",    32'(bus.MA_GNT_ID), 32'd3);
        checkOutput("lock_busy",   32'(bus.MA_BUSY),   32'd0);
        checkOutput("lock_memreq", 32'(bus.MEM_REQ),   32'd0);
        pushExpect(1, 1'b1, 32'h2000, 32'hCAFE_F00D, 4'hF, 32'hFFFF_DFFF, 1'b0, 2);
        bus.MA_PROG_LOCK = 1'b0;
        waitAcks(1, 20);

        // Memory never answers: timeout after four BUSY cycles.
        @(negedge clk);
        memEnable = 1'b0;
        pushExpect(2, 1'b0, 32'h80, 32'h0, 4'hF, 32'hDEAD_BEEF, 1'b1, 4);
        applyStimulus(2, 1'b0, 32'h80, 32'h0, 4'hF);
        waitAcks(1, 30);
        @(negedge clk);
        checkOutput("err_sticky", 32'(bus.MA_ERR), 32'd1);
        memEnable = 1'b1;

        // Reset between clock edges in the middle of a transaction.
        applyStimulus(1, 1'b0, 32'h500, 32'h0, 4'hF);
        @(negedge clk);
        checkOutput("pre_rst_memreq", 32'(bus.MEM_REQ), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("midrst_memreq", 32'(bus.MEM_REQ),   32'd0);
        checkOutput("midrst_busy",   32'(bus.MA_BUSY),   32'd0);
        checkOutput("midrst_gnt",    32'(bus.MA_GNT_ID), 32'd3);
        checkOutput("midrst_err",    32'(bus.MA_ERR),    32'd0);
        checkOutput("midrst_ack",    32'(bus.MA_ACK),    32'd0);
        bus.MA_REQ = 3'b000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        pushExpect(1, 1'b0, 32'h500, 32'h0, 4'hF, 32'hFFFF_FAFF, 1'b0, 2);
        applyStimulus(1, 1'b0, 32'h500, 32'h0, 4'hF);
        waitAcks(1, 20);
        repeat (2) @(negedge clk);
        checkOutput("queue_empty", 32'(expQ.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
